// File: rtl/arb_pkg.sv
// Shared types and constants for the 2-way round-robin arbiter and its requester-side queue.
package arb_pkg;

  typedef logic [0:0] client_id_t;

  localparam int unsigned NUM_CLIENTS = 2;
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_C0   = 2'b01;
  localparam logic [1:0] GRANT_C1   = 2'b10;

  function automatic logic is_onehot2(input logic [1:0] g);
    return (g == GRANT_C0) || (g == GRANT_C1);
  endfunction

endpackage

// File: rtl/rr_arb_client_queue_sync_fifo.sv
// Single-clock FIFO with a combinational head word; push when full and pop when empty are dropped.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: a flushed count makes every entry unreachable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rr_arb_client_queue.sv
// Requester-side queue for the 2-way round-robin arbiter: buffers two clients, raises requests,
// pops the granted FIFO onto a shared registered output and flags illegal grants.
import arb_pkg::*;

module rr_arb_client_queue #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] in_valid,
  input  logic [DATA_W-1:0]      in_data0,
  input  logic [DATA_W-1:0]      in_data1,
  output logic [NUM_CLIENTS-1:0] in_ready,
  output logic [NUM_CLIENTS-1:0] requests,
  input  logic [NUM_CLIENTS-1:0] grants,
  output logic                   out_valid,
  output client_id_t             out_id,
  output logic [DATA_W-1:0]      out_data,
  output logic                   grant_err
);

  // Handshake: a word moves from client i into FIFO i on a posedge where in_valid[i] && in_ready[i];
  // in_ready[i] and requests[i] come only from registered FIFO state. The output side has no ready:
  // out_valid is a one-cycle pulse per pop and the consumer must take it.

  logic [DATA_W-1:0] rdata0, rdata1;
  logic              empty0, empty1;
  logic              full0, full1;
  logic              push0, push1;
  logic              pop0, pop1;
  logic              grant_legal;

  logic              out_valid_q, out_valid_d;
  client_id_t        out_id_q, out_id_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              grant_err_q, grant_err_d;

  assign in_ready = {~full1, ~full0};
  assign requests = {~empty1, ~empty0};
  assign push0    = in_valid[0] && in_ready[0];
  assign push1    = in_valid[1] && in_ready[1];

  // A grant is usable only when exactly one bit is set and that client is actually requesting.
  assign grant_legal = is_onehot2(grants) && ((grants & requests) == grants);
  assign pop0        = grant_legal && (grants == GRANT_C0);
  assign pop1        = grant_legal && (grants == GRANT_C1);

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .pop   (pop0),
    .wdata (in_data0),
    .rdata (rdata0),
    .empty (empty0),
    .full  (full0)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .pop   (pop1),
    .wdata (in_data1),
    .rdata (rdata1),
    .empty (empty1),
    .full  (full1)
  );

  always_comb begin
    out_valid_d = pop0 || pop1;
    out_id_d    = out_id_q;
    out_data_d  = out_data_q;
    grant_err_d = (grants != GRANT_NONE) && !grant_legal;
    if (pop0) begin
      out_id_d   = client_id_t'(0);
      out_data_d = rdata0;
    end else if (pop1) begin
      out_id_d   = client_id_t'(1);
      out_data_d = rdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      grant_err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_data_q  <= out_data_d;
      grant_err_q <= grant_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_rr_arb_client_queue.sv
// Directed bench for rr_arb_client_queue: reset, single client, round-robin stream,
// full FIFO, illegal grants and mid-stream reset.
module tb_rr_arb_client_queue;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic [1:0]        in_valid;
  logic [DATA_W-1:0] in_data0;
  logic [DATA_W-1:0] in_data1;
  logic [1:0]        in_ready;
  logic [1:0]        requests;
  logic [1:0]        grants;
  logic              out_valid;
  logic [0:0]        out_id;
  logic [DATA_W-1:0] out_data;
  logic              grant_err;

  int checks;
  int errors;

  rr_arb_client_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_ready  (in_ready),
    .requests  (requests),
    .grants    (grants),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_data  (out_data),
    .grant_err (grant_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 2'b00;
    in_data0 = '0;
    in_data1 = '0;
    grants   = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (requests !== 2'b00) begin errors++; $display("FAIL reset_requests got %b exp 00", requests); end
    checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL reset_in_ready got %b exp 11", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL reset_grant_err got %b exp 0", grant_err); end
    checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL reset_out_id got %b exp 0", out_id); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
  endtask

  task automatic test_single();
    in_valid = 2'b01;
    in_data0 = 8'hA5;
    tick();
    in_valid = 2'b00;
    checks++; if (requests !== 2'b01) begin errors++; $display("FAIL single_req_rise got %b exp 01", requests); end
    grants = 2'b01;
    tick();
    grants = 2'b00;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", out_valid); end
    checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL single_id got %b exp 0", out_id); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", out_data); end
    checks++; if (requests !== 2'b00) begin errors++; $display("FAIL single_req_fall got %b exp 00", requests); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [DATA_W-1:0] exp_data [6];
    logic [0:0]        exp_id   [6];
    exp_data = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    exp_id   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      in_valid = 2'b11;
      in_data0 = 8'h10 + 8'(k);
      in_data1 = 8'h20 + 8'(k);
      tick();
    end
    in_valid = 2'b00;
    checks++; if (requests !== 2'b11) begin errors++; $display("FAIL rr_loaded_req got %b exp 11", requests); end
    for (int k = 0; k < 6; k++) begin
      grants = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b exp 1", k, out_valid); end
      checks++; if (out_id !== exp_id[k]) begin errors++; $display("FAIL rr_id[%0d] got %b exp %b", k, out_id, exp_id[k]); end
      checks++; if (out_data !== exp_data[k]) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", k, out_data, exp_data[k]); end
    end
    grants = 2'b00;
    checks++; if (requests !== 2'b00) begin errors++; $display("FAIL rr_end_req got %b exp 00", requests); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_end_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_full();
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_w;
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 2'b10;
      in_data1 = 8'h30 + 8'(k);
      exp_q.push_back(in_data1);
      tick();
    end
    checks++; if (in_ready !== 2'b01) begin errors++; $display("FAIL full_ready got %b exp 01", in_ready); end
    // Push offered while full, plus a grant: only the pop happens.
    in_valid = 2'b10;
    in_data1 = 8'h34;
    grants   = 2'b10;
    tick();
    exp_w = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin errors++; $display("FAIL full_pop0 got %b/%h exp 1/%h", out_valid, out_data, exp_w); end
    checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL full_ready_back got %b exp 11", in_ready); end
    // Same word now accepted with a concurrent pop: occupancy unchanged.
    tick();
    exp_q.push_back(8'h34);
    exp_w = exp_q.pop_front();
    in_valid = 2'b00;
    checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin errors++; $display("FAIL full_pop1 got %b/%h exp 1/%h", out_valid, out_data, exp_w); end
    checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL full_pushpop_ready got %b exp 11", in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_w = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_id !== 1'b1 || out_data !== exp_w) begin errors++; $display("FAIL full_drain[%0d] got %b/%b/%h exp 1/1/%h", k, out_valid, out_id, out_data, exp_w); end
    end
    grants = 2'b00;
    checks++; if (requests !== 2'b00) begin errors++; $display("FAIL full_end_req got %b exp 00", requests); end
    // Last-word pop with a same-cycle push keeps requests high.
    in_valid = 2'b01;
    in_data0 = 8'h40;
    tick();
    in_data0 = 8'h41;
    grants   = 2'b01;
    tick();
    in_valid = 2'b00;
    checks++; if (out_data !== 8'h40 || requests !== 2'b01) begin errors++; $display("FAIL lastpop_push got %h/%b exp 40/01", out_data, requests); end
    tick();
    grants = 2'b00;
    checks++; if (out_data !== 8'h41 || requests !== 2'b00) begin errors++; $display("FAIL lastpop_drain got %h/%b exp 41/00", out_data, requests); end
    tick();
  endtask

  task automatic test_illegal();
    in_valid = 2'b11;
    in_data0 = 8'h50;
    in_data1 = 8'h60;
    tick();
    in_valid = 2'b00;
    grants   = 2'b11;
    tick();
    grants = 2'b00;
    checks++; if (grant_err !== 1'b1) begin errors++; $display("FAIL ill11_err got %b exp 1", grant_err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill11_nopop got %b exp 0", out_valid); end
    checks++; if (requests !== 2'b11) begin errors++; $display("FAIL ill11_req got %b exp 11", requests); end
    tick();
    checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL ill11_pulse got %b exp 0", grant_err); end
    grants = 2'b01;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h50 || grant_err !== 1'b0) begin errors++; $display("FAIL ill_legal_pop got %b/%h/%b exp 1/50/0", out_valid, out_data, grant_err); end
    // requests is now 10; grant 01 names an idle client.
    tick();
    grants = 2'b00;
    checks++; if (grant_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ill01_err got %b/%b exp 1/0", grant_err, out_valid); end
    checks++; if (requests !== 2'b10) begin errors++; $display("FAIL ill01_req got %b exp 10", requests); end
    grants = 2'b11;
    tick();
    grants = 2'b00;
    checks++; if (grant_err !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL ill11_one_side got %b/%b exp 1/0", grant_err, out_valid); end
    grants = 2'b10;
    tick();
    grants = 2'b00;
    checks++; if (out_valid !== 1'b1 || out_id !== 1'b1 || out_data !== 8'h60 || grant_err !== 1'b0) begin errors++; $display("FAIL ill_recover got %b/%b/%h/%b exp 1/1/60/0", out_valid, out_id, out_data, grant_err); end
    checks++; if (requests !== 2'b00) begin errors++; $display("FAIL ill_end_req got %b exp 00", requests); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    for (int k = 0; k < 3; k++) begin
      in_valid = 2'b11;
      in_data0 = 8'h70 + 8'(k);
      in_data1 = 8'h80 + 8'(k);
      tick();
    end
    in_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (requests !== 2'b00) begin errors++; $display("FAIL rstmid_req got %b exp 00", requests); end
    checks++; if (in_ready !== 2'b11) begin errors++; $display("FAIL rstmid_ready got %b exp 11", in_ready); end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_output got %0d exp 0", seen); end
    in_valid = 2'b01;
    in_data0 = 8'h90;
    tick();
    in_valid = 2'b00;
    checks++; if (requests !== 2'b01) begin errors++; $display("FAIL rstmid_push_req got %b exp 01", requests); end
    grants = 2'b01;
    tick();
    grants = 2'b00;
    checks++; if (out_valid !== 1'b1 || out_id !== 1'b0 || out_data !== 8'h90) begin errors++; $display("FAIL rstmid_pop got %b/%b/%h exp 1/0/90", out_valid, out_id, out_data); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
